// File: rtl/mdr_if.sv
// Bus bundle between the control FSM / register B side, the data memory and the
// memory data register unit.
interface mdr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_BITS  = 2
);
  logic                    mem_read;
  logic                    mem_write;
  logic [LANE_BITS-1:0]    addr_lo;
  logic [1:0]              size;
  logic                    sign_ext;
  logic [DATA_WIDTH-1:0]   reg_b;
  logic [DATA_WIDTH-1:0]   dmem_rdata;
  logic                    dmem_ready;
  logic                    dmem_req;
  logic                    dmem_we;
  logic [DATA_WIDTH/8-1:0] dmem_be;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH-1:0]   mdr_out;
  logic                    busy;
  logic                    done;
  logic                    misaligned;
  logic                    timeout;

  modport master (
    output mem_read, mem_write, addr_lo, size, sign_ext, reg_b, dmem_rdata, dmem_ready,
    input  dmem_req, dmem_we, dmem_be, dmem_wdata, mdr_out, busy, done, misaligned, timeout
  );

  modport slave (
    input  mem_read, mem_write, addr_lo, size, sign_ext, reg_b, dmem_rdata, dmem_ready,
    output dmem_req, dmem_we, dmem_be, dmem_wdata, mdr_out, busy, done, misaligned, timeout
  );
endinterface

// File: rtl/mdr_unit.sv
// Memory data register unit: one load/store at a time over a req/ready handshake,
// sub-word load extraction into a held MDR, store lane replication and byte enables.
//
// state      | meaning
// IDLE       | waiting for mem_read / mem_write
// READ_WAIT  | load request outstanding
// WRITE_WAIT | store request outstanding
// DONE       | one-cycle completion pulse (normal, misaligned or timeout)
module mdr_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic  clk,
  input logic  rst,
  mdr_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

  state_t               state, state_nx;
  logic [7:0]           cnt, cnt_nx, cnt_inc;
  logic [LANE_BITS-1:0] lane_q, lane_nx;
  logic [1:0]           size_q, size_nx;
  logic                 sext_q, sext_nx;

  logic                  req_q, req_nx, we_q, we_nx;
  logic [NB-1:0]         be_q, be_nx;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nx, mdr_q, mdr_nx;
  logic                  busy_q, busy_nx, done_q, done_nx;
  logic                  mis_q, mis_nx, to_q, to_nx;

  logic                  aligned;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_val;

  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.addr_lo[0];
      2'b10:   aligned = (bus.addr_lo == '0);
      default: aligned = 1'b0;
    endcase
  end

  // Load lane selection uses the offset/size latched at command time.
  assign lane_byte = bus.dmem_rdata[{lane_q, 3'b000} +: 8];
  assign lane_half = bus.dmem_rdata[{lane_q[LANE_BITS-1:1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{(DATA_WIDTH-8){sext_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{(DATA_WIDTH-16){sext_q & lane_half[15]}}, lane_half};
      default: load_val = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lane_nx  = lane_q;
    size_nx  = size_q;
    sext_nx  = sext_q;
    req_nx   = 1'b0;
    we_nx    = 1'b0;
    be_nx    = '0;
    wdata_nx = '0;
    mdr_nx   = mdr_q;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    mis_nx   = 1'b0;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          if (!aligned) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            mis_nx   = 1'b1;
          end else begin
            lane_nx = bus.addr_lo;
            size_nx = bus.size;
            sext_nx = bus.sign_ext;
            cnt_nx  = '0;
            req_nx  = 1'b1;
            busy_nx = 1'b1;
            if (bus.mem_read) begin
              state_nx = READ_WAIT;
              be_nx    = '1;
            end else begin
              state_nx = WRITE_WAIT;
              we_nx    = 1'b1;
              case (bus.size)
                2'b00: begin
                  wdata_nx = {NB{bus.reg_b[7:0]}};
                  be_nx    = NB'(1) << bus.addr_lo;
                end
                2'b01: begin
                  wdata_nx = {(NB/2){bus.reg_b[15:0]}};
                  be_nx    = NB'(3) << bus.addr_lo;
                end
                default: begin
                  wdata_nx = bus.reg_b;
                  be_nx    = '1;
                end
              endcase
            end
          end
        end
      end
      READ_WAIT, WRITE_WAIT: begin
        we_nx    = we_q;
        be_nx    = be_q;
        wdata_nx = wdata_q;
        if (bus.dmem_ready) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          if (state == READ_WAIT) mdr_nx = load_val;
        end else if (cnt_inc == 8'(TIMEOUT_CYCLES)) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          to_nx    = 1'b1;
          cnt_nx   = cnt_inc;
        end else begin
          cnt_nx  = cnt_inc;
          req_nx  = 1'b1;
          busy_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lane_q  <= lane_nx;
      size_q  <= size_nx;
      sext_q  <= sext_nx;
      req_q   <= req_nx;
      we_q    <= we_nx;
      be_q    <= be_nx;
      wdata_q <= wdata_nx;
      mdr_q   <= mdr_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      mis_q   <= mis_nx;
      to_q    <= to_nx;
    end
  end

  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.mdr_out    = mdr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.misaligned = mis_q;
  assign bus.timeout    = to_q;
endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit: transaction-level reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_mdr_unit;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdr_if #(.DATA_WIDTH(32), .LANE_BITS(2)) bus ();

  mdr_unit #(.DATA_WIDTH(32), .LANE_BITS(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks one outstanding transaction with plain integers.
  int          m_active = 0, m_read = 0, m_addr = 0, m_size = 0, m_sext = 0, m_waits = 0;
  logic        e_req = 0, e_we = 0, e_busy = 0, e_done = 0, e_mis = 0, e_to = 0;
  logic [3:0]  e_be = 0;
  logic [31:0] e_wdata = 0, e_mdr = 0;

  function automatic logic [31:0] load_model(logic [31:0] d, int a, int sz, int s);
    logic [31:0] v;
    if (sz == 2) return d;
    if (sz == 0) begin
      v = (d >> (8 * a)) & 32'hFF;
      if (s != 0 && v >= 128) v = v - 32'd256;
    end else begin
      v = (d >> (8 * a)) & 32'hFFFF;
      if (s != 0 && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0;
      {e_req, e_we, e_busy, e_done, e_mis, e_to} = '0;
      e_be = 0; e_wdata = 0; e_mdr = 0;
    end else if (m_active != 0) begin
      if (bus.dmem_ready) begin
        if (m_read != 0) e_mdr = load_model(bus.dmem_rdata, m_addr, m_size, m_sext);
        m_active = 0; e_done = 1;
      end else begin
        m_waits++;
        if (m_waits == TMO) begin
          m_active = 0; e_done = 1; e_to = 1;
        end
      end
      if (m_active == 0) begin
        e_req = 0; e_busy = 0; e_we = 0; e_be = 0; e_wdata = 0;
      end
    end else if (e_done) begin
      e_done = 0; e_mis = 0; e_to = 0;
    end else if (bus.mem_read || bus.mem_write) begin
      m_addr = int'(bus.addr_lo); m_size = int'(bus.size); m_sext = int'(bus.sign_ext);
      if (!(m_size == 0 || (m_size == 1 && m_addr % 2 == 0) || (m_size == 2 && m_addr == 0))) begin
        e_done = 1; e_mis = 1;
      end else begin
        m_active = 1; m_waits = 0; m_read = bus.mem_read ? 1 : 0;
        e_req = 1; e_busy = 1;
        if (m_read != 0) begin
          e_we = 0; e_be = 4'hF; e_wdata = 0;
        end else begin
          e_we = 1;
          case (m_size)
            0: begin e_wdata = (bus.reg_b & 32'hFF) * 32'h01010101;   e_be = 4'(1 << m_addr); end
            1: begin e_wdata = (bus.reg_b & 32'hFFFF) * 32'h00010001; e_be = 4'(3 << m_addr); end
            default: begin e_wdata = bus.reg_b; e_be = 4'hF; end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_req", 32'(bus.dmem_req), 32'(e_req));
      chk("mon_busy", 32'(bus.busy), 32'(e_busy));
      chk("mon_done", 32'(bus.done), 32'(e_done));
      chk("mon_mis", 32'(bus.misaligned), 32'(e_mis));
      chk("mon_to", 32'(bus.timeout), 32'(e_to));
      chk("mon_mdr", bus.mdr_out, e_mdr);
      if (e_req) begin
        chk("mon_we", 32'(bus.dmem_we), 32'(e_we));
        chk("mon_be", 32'(bus.dmem_be), 32'(e_be));
        chk("mon_wdata", bus.dmem_wdata, e_wdata);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic cmd(input bit rd, input bit wr, input int a, input int sz, input bit s,
                     input logic [31:0] rb);
    bus.mem_read = rd; bus.mem_write = wr; bus.addr_lo = 2'(a); bus.size = 2'(sz);
    bus.sign_ext = s; bus.reg_b = rb;
    @(negedge clk);
    bus.mem_read = 0; bus.mem_write = 0;
  endtask

  task automatic finish_xfer(input int waits, input logic [31:0] rdata, input string tag,
                             input logic [31:0] exp_mdr);
    repeat (waits) @(negedge clk);
    bus.dmem_ready = 1; bus.dmem_rdata = rdata;
    @(negedge clk);
    bus.dmem_ready = 0;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_to"}, 32'(bus.timeout), 32'd0);
    chk({tag, "_mdr"}, bus.mdr_out, exp_mdr);
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.addr_lo = 0; bus.size = 0; bus.sign_ext = 0;
    bus.reg_b = 0; bus.dmem_rdata = 0; bus.dmem_ready = 0;
    @(negedge clk);
    mon_en = 1;
    @(negedge clk);
    chk("rst_mdr", bus.mdr_out, 32'h0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    rst = 0;
    @(negedge clk);

    cmd(1, 0, 0, 2, 0, 0);
    chk("wl_be", 32'(bus.dmem_be), 32'hF);
    finish_xfer(3, 32'hDEADBEEF, "wl", 32'hDEADBEEF);

    cmd(1, 0, 3, 0, 1, 0); finish_xfer(0, 32'h80FF7F01, "lb3s", 32'hFFFFFF80);
    cmd(1, 0, 1, 0, 0, 0); finish_xfer(1, 32'h80FF7F01, "lb1z", 32'h0000007F);
    cmd(1, 0, 2, 1, 1, 0); finish_xfer(2, 32'h80FF7F01, "lh2s", 32'hFFFF80FF);

    cmd(0, 1, 2, 0, 0, 32'h123456AB);
    chk("sb_wdata", bus.dmem_wdata, 32'hABABABAB);
    chk("sb_be", 32'(bus.dmem_be), 32'b0100);
    chk("sb_we", 32'(bus.dmem_we), 32'd1);
    finish_xfer(1, 32'h55555555, "sb", 32'hFFFF80FF);

    cmd(0, 1, 2, 1, 0, 32'h0000BEEF);
    chk("sh_be", 32'(bus.dmem_be), 32'b1100);
    chk("sh_wdata", bus.dmem_wdata, 32'hBEEFBEEF);
    finish_xfer(0, 32'h0, "sh", 32'hFFFF80FF);

    cmd(1, 0, 1, 1, 0, 0);
    chk("mis_flag", 32'(bus.misaligned), 32'd1);
    chk("mis_done", 32'(bus.done), 32'd1);
    chk("mis_req", 32'(bus.dmem_req), 32'd0);
    chk("mis_mdr", bus.mdr_out, 32'hFFFF80FF);
    @(negedge clk);

    cmd(1, 0, 0, 2, 0, 0);
    repeat (TMO - 1) @(negedge clk);
    chk("to_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("to_done", 32'(bus.done), 32'd1);
    chk("to_flag", 32'(bus.timeout), 32'd1);
    chk("to_mdr", bus.mdr_out, 32'hFFFF80FF);
    @(negedge clk);

    cmd(1, 0, 0, 2, 0, 0);
    finish_xfer(TMO - 1, 32'h00001234, "last", 32'h00001234);

    cmd(1, 1, 0, 2, 0, 32'h99999999);
    chk("col_we", 32'(bus.dmem_we), 32'd0);
    // A command while busy must be dropped, not queued.
    bus.mem_write = 1; bus.size = 2'b10; bus.addr_lo = 0;
    @(negedge clk);
    bus.mem_write = 0;
    chk("busy_we", 32'(bus.dmem_we), 32'd0);
    finish_xfer(0, 32'hCAFEF00D, "col", 32'hCAFEF00D);
    @(negedge clk);
    chk("busy_ignored", 32'(bus.dmem_req), 32'd0);

    cmd(1, 0, 0, 2, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mrst_req", 32'(bus.dmem_req), 32'd0);
    chk("mrst_mdr", bus.mdr_out, 32'h0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("mrst_nodone", 32'(bus.done), 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
